// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: returns magnitude and atan2 phase (2^20 = 360 deg) of a signed vector.
// Optional macro CORDIC_GAIN_COMP_EN scales the magnitude by ~1/K so it reports the true length.
module cordic_vectoring #(
    parameter int WIDTH = 10,
    parameter int ITER  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH+1:0] magnitude,
    output logic [19:0]      phase
);
    localparam int XW = WIDTH + 2;
    localparam logic [4:0] LAST = 5'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        ITERATE,
        FINISH
    } state_t;

    state_t               state;
    logic [4:0]           cnt;
    logic signed [XW-1:0] x;
    logic signed [XW-1:0] y;
    logic signed [19:0]   z;
    logic                 zero_vec;

    logic signed [XW-1:0] x_ext;
    logic signed [XW-1:0] y_ext;
    logic signed [XW-1:0] x_shift;
    logic signed [XW-1:0] y_shift;
    logic signed [19:0]   atan_val;
    logic [XW-1:0]        mag_next;

    // atan(2^-i) in the 20-bit angle format, rounded to nearest
    function automatic logic [19:0] atan_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_rom = 20'h20000;
            5'd1:    atan_rom = 20'h12E40;
            5'd2:    atan_rom = 20'h09FB4;
            5'd3:    atan_rom = 20'h05111;
            5'd4:    atan_rom = 20'h028B1;
            5'd5:    atan_rom = 20'h0145D;
            5'd6:    atan_rom = 20'h00A2F;
            5'd7:    atan_rom = 20'h00518;
            5'd8:    atan_rom = 20'h0028C;
            5'd9:    atan_rom = 20'h00146;
            5'd10:   atan_rom = 20'h000A3;
            5'd11:   atan_rom = 20'h00051;
            5'd12:   atan_rom = 20'h00029;
            5'd13:   atan_rom = 20'h00014;
            5'd14:   atan_rom = 20'h0000A;
            5'd15:   atan_rom = 20'h00005;
            5'd16:   atan_rom = 20'h00003;
            5'd17:   atan_rom = 20'h00001;
            default: atan_rom = 20'h00000;
        endcase
    endfunction

    assign x_ext    = {{2{x_in[WIDTH-1]}}, x_in};
    assign y_ext    = {{2{y_in[WIDTH-1]}}, y_in};
    assign x_shift  = x >>> cnt;
    assign y_shift  = y >>> cnt;
    assign atan_val = atan_rom(cnt);

`ifdef CORDIC_GAIN_COMP_EN
    // x * 311/512 = x/2 + x/8 - x/64 - x/512, kept wide so only the final shift truncates
    logic [XW+8:0] x_wide;
    logic [XW+8:0] scaled;
    assign x_wide   = {9'b0, x};
    assign scaled   = (x_wide << 8) + (x_wide << 6) - (x_wide << 3) - x_wide;
    assign mag_next = XW'(scaled >> 9);
`else
    assign mag_next = x;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            zero_vec  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            magnitude <= '0;
            phase     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        cnt      <= '0;
                        zero_vec <= (x_in == '0) && (y_in == '0);
                        state    <= ITERATE;
                        // Fold the left half-plane onto the right so iterations converge
                        if (!x_ext[XW-1]) begin
                            x <= x_ext;
                            y <= y_ext;
                            z <= 20'sh00000;
                        end else if (!y_ext[XW-1]) begin
                            x <= y_ext;
                            y <= -x_ext;
                            z <= 20'sh40000;
                        end else begin
                            x <= -y_ext;
                            y <= x_ext;
                            z <= 20'shC0000;
                        end
                    end
                end
                ITERATE: begin
                    if (!y[XW-1]) begin
                        x <= x + y_shift;
                        y <= y - x_shift;
                        z <= z + atan_val;
                    end else begin
                        x <= x - y_shift;
                        y <= y + x_shift;
                        z <= z - atan_val;
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    magnitude <= zero_vec ? '0 : mag_next;
                    phase     <= zero_vec ? 20'h00000 : z;
                    cnt       <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_vectoring.sv
// Self-checking bench for cordic_vectoring: directed and random vectors against an ideal
// floating-point magnitude/atan2 model, plus handshake, latency and reset-abort checks.
module tb_cordic_vectoring;
    // WIDTH=11 so the x=800 case and the -1024 boundary are both representable
    localparam int WIDTH = 11;
    localparam int ITER  = 16;
    localparam real PI = 3.14159265358979;
    localparam real LSB_PER_RAD = 1048576.0 / (2.0 * PI);
`ifdef CORDIC_GAIN_COMP_EN
    localparam bit COMP = 1'b1;
`else
    localparam bit COMP = 1'b0;
`endif
    localparam int MAG_TOL = COMP ? 14 : 20;

    logic             clock;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;
    logic             busy;
    logic             done;
    logic [WIDTH+1:0] magnitude;
    logic [19:0]      phase;

    int  checks = 0;
    int  passes = 0;
    real kgain;

    cordic_vectoring #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .x_in     (x_in),
        .y_in     (y_in),
        .busy     (busy),
        .done     (done),
        .magnitude(magnitude),
        .phase    (phase)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) passes++;
        else $error("[TB] FAIL %s: got %0d, expected %0d", tag, got, expv);
    endtask

    task automatic check_near(input string tag, input int got, input int expv, input int tol,
                              input bit wrap);
        int diff;
        logic signed [19:0] d20;
        diff = got - expv;
        if (wrap) begin
            d20  = 20'(diff);
            diff = int'(d20);
        end
        if (diff < 0) diff = -diff;
        checks++;
        assert ((diff <= tol) === 1'b1) passes++;
        else $error("[TB] FAIL %s: got %0d, expected %0d +/- %0d", tag, got, expv, tol);
    endtask

    // Ideal model: K*|v| (or |v| with gain compensation) and atan2 scaled to 2^20 per turn
    task automatic check_output(input string tag, input int vx, input int vy);
        real len;
        real emag;
        real eph;
        int  ptol;
        if (vx == 0 && vy == 0) begin
            check_eq({tag, "_mag"}, 32'(magnitude), 32'd0);
            check_eq({tag, "_phase"}, 32'(phase), 32'd0);
        end else begin
            len  = $sqrt(real'(vx * vx + vy * vy));
            emag = COMP ? len : len * kgain;
            eph  = $atan2(real'(vy), real'(vx)) * LSB_PER_RAD;
            ptol = 16 + int'(16.0 * LSB_PER_RAD / (len * kgain));
            check_near({tag, "_mag"}, int'(magnitude), int'(emag), MAG_TOL, 1'b0);
            check_near({tag, "_phase"}, int'(phase), int'(eph), ptol, 1'b1);
        end
    endtask

    task automatic apply_stimulus(input int vx, input int vy, output int lat);
        @(negedge clock);
        x_in  = WIDTH'(vx);
        y_in  = WIDTH'(vy);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check_eq("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 64) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
    endtask

    task automatic rand_vec(output int vx, output int vy);
        do begin
            vx = int'($urandom_range(0, 2047)) - 1024;
            vy = int'($urandom_range(0, 2047)) - 1024;
        end while (vx * vx + vy * vy < 300 * 300);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    int dir_x[8] = '{800, 0, -400, -512, -1024, 0, 1023, -1024};
    int dir_y[8] = '{0, 400, -400, 0, -1024, -1024, 1023, 1023};
    int xs[128];
    int ys[128];

    initial begin
        int lat, vx, vy, e, acc, prev_done, ndone;

        kgain = 1.0;
        for (int i = 0; i < ITER; i++) kgain = kgain * $sqrt(1.0 + 1.0 / (4.0 ** i));

        reset = 1'b1;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_mag", 32'(magnitude), 32'd0);
        check_eq("reset_phase", 32'(phase), 32'd0);
        reset = 1'b0;

        for (int t = 0; t < 8; t++) begin
            apply_stimulus(dir_x[t], dir_y[t], lat);
            check_eq($sformatf("dir%0d_latency", t), 32'(lat), 32'(ITER + 1));
            check_output($sformatf("dir%0d", t), dir_x[t], dir_y[t]);
            @(negedge clock);
            check_eq($sformatf("dir%0d_done_pulse", t), 32'(done), 32'd0);
            repeat (2) @(negedge clock);
            check_output($sformatf("dir%0d_hold", t), dir_x[t], dir_y[t]);
        end

        for (int t = 0; t < 8; t++) begin
            rand_vec(vx, vy);
            apply_stimulus(vx, vy, lat);
            check_eq($sformatf("rnd%0d_latency", t), 32'(lat), 32'(ITER + 1));
            check_output($sformatf("rnd%0d", t), vx, vy);
        end

        // Start held high with inputs changing every cycle: results must track accept-edge inputs
        @(negedge clock);
        start = 1'b1;
        e = 0;
        prev_done = -1;
        ndone = 0;
        while (e < 3 * (ITER + 2) + 2) begin
            rand_vec(vx, vy);
            x_in = WIDTH'(vx);
            y_in = WIDTH'(vy);
            xs[e + 1] = vx;
            ys[e + 1] = vy;
            @(posedge clock);
            e++;
            @(negedge clock);
            if (done === 1'b1) begin
                acc = e - (ITER + 1);
                if (acc < 1) acc = 1;
                check_output($sformatf("b2b%0d", ndone), xs[acc], ys[acc]);
                if (prev_done >= 0) check_eq("b2b_gap", 32'(e - prev_done), 32'(ITER + 2));
                prev_done = e;
                ndone++;
            end
        end
        start = 1'b0;
        check_eq("b2b_done_count", 32'(ndone), 32'd3);
        do_reset();

        // Abort mid-iteration with reset, then a zero vector
        @(negedge clock);
        x_in  = WIDTH'(700);
        y_in  = WIDTH'(-300);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_mag", 32'(magnitude), 32'd0);
        check_eq("abort_phase", 32'(phase), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < ITER + 6; c++) begin
            @(negedge clock);
            if (done === 1'b1) ndone++;
        end
        check_eq("abort_no_done", 32'(ndone), 32'd0);
        apply_stimulus(0, 0, lat);
        check_eq("zero_latency", 32'(lat), 32'(ITER + 1));
        check_output("zero", 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
